uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Line-side UART transmitter that feeds the memory-mapped UART controller. It accepts bytes on TX_DATA/TX_EN and reports readiness on TX_STATUS. It serialises each byte as an 8N1 frame on UART_TX at a fixed bit period. A one-entry holding register lets the controller queue the next byte while the current frame is on the wire, giving gap-free back-to-back frames.

Parameters:
CLKS_PER_BIT, 10417, clk cycles per bit period (100 MHz / 9600 baud); must be >= 2
DATA_BITS, 8, payload bits per frame; fixed 8 in this design, exposed for the package constant only

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
TX_DATA  input  8  byte to transmit, sampled with TX_EN
TX_EN  input  1  write strobe; 1-cycle pulse, accepted only when TX_STATUS=1
TX_STATUS  output  1  1 = can accept a byte (holding register empty)
TX_BUSY  output  1  1 = a frame is currently being shifted out
UART_TX  output  1  serial line, idle high

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: UART_TX=1, TX_STATUS=1, TX_BUSY=0, state IDLE, bit timer=0, bit index=0, holding register empty.
- Reset mid-frame: abort at that edge; UART_TX=1 from the next cycle; holding-register contents are discarded.
- Acceptance: TX_EN=1 and TX_STATUS=1 at a rising edge.
  - Shifter free (IDLE, or last stop cycle ending at this edge): the byte loads directly into the shifter.
  - Otherwise the byte is stored in the holding register.
  - TX_EN while TX_STATUS=0 is ignored; no state change, byte dropped.
- TX_STATUS is the inverse of the hold-full flop. It is registered, so it changes the cycle after acceptance.
- Latency: TX_EN accepted at edge N from IDLE gives UART_TX=0 (start bit) in cycle N+1. TX_BUSY=1 from cycle N+1.
- FSM states:
  - IDLE: UART_TX=1. Leave to START on a direct load.
  - START: UART_TX=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: UART_TX=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles. The bit index counts 0..7, and the state goes to STOP after bit 7.
  - STOP: UART_TX=1 for CLKS_PER_BIT cycles. On the final cycle:
    - if holding register full: move it into the shifter, clear hold-full, go to START (no idle gap); TX_STATUS=1 next cycle;
    - else if TX_EN accepted on that edge: load directly, go to START;
    - else: go to IDLE, TX_BUSY=0 next cycle.
- Frame length is exactly 10*CLKS_PER_BIT cycles; consecutive frames are contiguous.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width is clog2(CLKS_PER_BIT); it does not count in IDLE.
- UART_TX and TX_BUSY are driven from flops (glitch-free line).
- TX_DATA is sampled only at acceptance; later changes do not affect a queued or in-flight byte.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, START, DATA, STOP), FRAME_BITS=10, DATA_BITS=8, default CLKS_PER_BIT. The future receiver reuses the same package.
- One natural sub-module: uart_bit_timer (parameterised by CLKS_PER_BIT; enable input, bit_done pulse on the last cycle of each bit period). Everything else lives in the top.

Test Plan:
- CLKS_PER_BIT=4: after reset with TX_EN held low for 100 cycles -> UART_TX=1, TX_STATUS=1, TX_BUSY=0 throughout.
- Send 0x55 from IDLE -> UART_TX low from cycle N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then stop high 4 cycles; TX_BUSY high for exactly 40 cycles; TX_STATUS never drops.
- Send 0xA5, then 0x3C 5 cycles later -> TX_STATUS=0 from the next cycle until the 0xA5 stop bit ends. The 0x3C start bit immediately follows the 0xA5 stop bit, giving 80 contiguous busy cycles.
- With hold full, pulse TX_EN with 0xFF -> ignored; only 0xA5 and 0x3C appear on the line.
- Send 0x3C, then pulse TX_EN with 0x81 exactly on the last stop cycle with hold empty -> the 0x81 start bit begins the next cycle, no idle gap.
- Assert reset during bit D3 of 0x0F, with a queued byte -> UART_TX=1, TX_STATUS=1, TX_BUSY=0 the next cycle; the queued byte is never transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit period and the line FSM states.
// Used by the transmitter and intended for the matching receiver.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 10;
  localparam int DEF_CLKS_PER_BIT = 10417;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle
// of each bit period. Held at zero while disabled so every frame starts on a fresh period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_done
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign bit_done = enable && (count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a one-byte holding register so the next byte can be
// queued while a frame is on the wire, giving back-to-back frames with no idle gap.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_EN,
  output logic                 TX_STATUS,
  output logic                 TX_BUSY,
  output logic                 UART_TX,
  output uart_state_t          debug_state
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic                 hold_full, hold_full_next;
  logic [DATA_BITS-1:0] hold_data, hold_data_next;
  logic                 line_q, line_next;
  logic                 busy_q;
  logic                 bit_done;
  logic                 accept;
  logic                 load_direct;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (state != IDLE),
    .bit_done (bit_done)
  );

  // Handshake: a byte is taken on any edge where TX_EN=1 and TX_STATUS=1
  // (holding register empty); TX_EN while TX_STATUS=0 is dropped with no effect.
  assign accept = TX_EN && !hold_full;

  always_comb begin
    state_next     = state;
    shift_next     = shift;
    bit_idx_next   = bit_idx;
    hold_full_next = hold_full;
    hold_data_next = hold_data;
    load_direct    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) load_direct = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == LAST_IDX) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
            shift_next   = shift >> 1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (hold_full) begin
            state_next     = START;
            shift_next     = hold_data;
            hold_full_next = 1'b0;
          end else if (accept) begin
            load_direct = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load_direct) begin
      state_next = START;
      shift_next = TX_DATA;
    end else if (accept) begin
      hold_full_next = 1'b1;
      hold_data_next = TX_DATA;
    end

    // Line value is precomputed from the next state so UART_TX comes straight off a flop.
    if (state_next == DATA) begin
      line_next = shift_next[0];
    end else begin
      line_next = (state_next != START);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      shift     <= shift_next;
      bit_idx   <= bit_idx_next;
      hold_full <= hold_full_next;
      hold_data <= hold_data_next;
      line_q    <= line_next;
      busy_q    <= (state_next != IDLE);
    end
  end

  assign TX_STATUS   = !hold_full;
  assign TX_BUSY     = busy_q;
  assign UART_TX     = line_q;
  assign debug_state = state;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a waveform-queue reference model predicts the line,
// busy and ready outputs every cycle for directed and random byte traffic.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_en = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_status;
  logic        tx_busy;
  logic        uart_tx;
  uart_state_t dbg_state;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .TX_DATA     (tx_data),
    .TX_EN       (tx_en),
    .TX_STATUS   (tx_status),
    .TX_BUSY     (tx_busy),
    .UART_TX     (uart_tx),
    .debug_state (dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of future line levels, one entry per clock cycle,
  // plus a single pending byte that waits for the queue to run dry.
  logic [0:0] exp_q[$];
  logic       hold_valid = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  function automatic void push_frame(input logic [7:0] b);
    logic [0:0] lvl;
    for (int f = 0; f < FRAME_BITS; f++) begin
      if (f == 0) lvl = 1'b0;
      else if (f == FRAME_BITS - 1) lvl = 1'b1;
      else lvl = b[f-1];
      for (int c = 0; c < CPB; c++) exp_q.push_back(lvl);
    end
  endfunction

  always @(posedge clk) begin : model
    logic       accept;
    logic [31:0] exp_line;
    accept = tx_en && !hold_valid;
    if (reset) begin
      exp_q.delete();
      hold_valid = 1'b0;
    end else begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        if (hold_valid) begin
          push_frame(hold_byte);
          hold_valid = 1'b0;
        end else if (accept) begin
          push_frame(tx_data);
        end
      end else if (accept) begin
        hold_valid = 1'b1;
        hold_byte  = tx_data;
      end
    end
    #1;
    exp_line = (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd1;
    check("uart_tx", 32'(uart_tx), exp_line);
    check("tx_busy", 32'(tx_busy), 32'(exp_q.size() != 0));
    check("tx_status", 32'(tx_status), 32'(!hold_valid));
    if (exp_q.size() == 0) check("idle_state", 32'(dbg_state), 32'(IDLE));
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_en   = 1'b1;
    tx_data = b;
    @(negedge clk);
    tx_en   = 1'b0;
    tx_data = 8'($urandom_range(0, 255));
  endtask

  // Drive TX_EN for the very next edge without first waiting for a negedge.
  task automatic pulse_now(input logic [7:0] b);
    tx_en   = 1'b1;
    tx_data = b;
    @(negedge clk);
    tx_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((tx_busy || !tx_status) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {30'd0, tx_busy, tx_status}, 32'b01);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);

    send_byte(8'h55);
    wait_idle("after_55");
    repeat (5) @(negedge clk);

    send_byte(8'hA5);
    repeat (3) @(negedge clk);
    send_byte(8'h3C);
    repeat (2) @(negedge clk);
    send_byte(8'hFF);
    wait_idle("after_a5_3c");
    repeat (5) @(negedge clk);

    send_byte(8'h3C);
    repeat (39) @(negedge clk);
    pulse_now(8'h81);
    wait_idle("after_3c_81");
    repeat (5) @(negedge clk);

    send_byte(8'h0F);
    send_byte(8'h77);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle("drain");
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
